// File: rtl/decode_operand_fetch.sv
// Decode / operand-fetch stage: issues one instruction per cycle into registered execute
// outputs, with register-file bypass, forwarding hints and a one-entry pending-load scoreboard.
module decode_operand_fetch #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        wr_en,
    input  logic [3:0]  wr_reg,
    input  logic [15:0] wr_val,
    input  logic        ld_done,
    input  logic [15:0] ld_val,
    output logic [3:0]  opcode,
    output logic [3:0]  destReg,
    output logic [15:0] srcVal1,
    output logic [15:0] srcVal2,
    output logic [7:0]  memAddr,
    output logic        used1,
    output logic        used2,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpHlt   = 4'd1;
    localparam logic [3:0] OpNot   = 4'd9;
    localparam logic [3:0] OpLoad  = 4'd14;
    localparam logic [3:0] OpStore = 4'd15;

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StStall  = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    logic [1:0]  stateQ, stateD;
    logic        pendQ, pendD;
    logic [3:0]  pendRegQ, pendRegD;
    logic        illegalQ;
    logic [15:0] regFile [16];

    logic [3:0]  op, fDst, fS1, fS2, rdReg1;
    logic        isAlu, isLoad, isStore, isIllegal, isHlt;
    logic        readsR1, readsR2, writesDst;
    logic        hazard, accept, ldWrite, prevAlu;
    logic [15:0] rdVal1, rdVal2;

    logic [3:0]  opD, dstD;
    logic [15:0] s1D, s2D;
    logic [7:0]  addrD;
    logic        u1D, u2D;

    assign op     = instr[15:12];
    assign fDst   = instr[11:8];
    assign fS1    = instr[7:4];
    assign fS2    = instr[3:0];

    assign isAlu     = (op >= 4'd2) && (op <= 4'd10);
    assign isIllegal = (op >= 4'd11) && (op <= 4'd13);
    assign isLoad    = (op == OpLoad);
    assign isStore   = (op == OpStore);
    assign isHlt     = (op == OpHlt) || (isIllegal && HALT_ON_ILLEGAL);

    // STORE carries its data register in the destination field
    assign rdReg1    = isStore ? fDst : fS1;
    assign readsR1   = isAlu || isStore;
    assign readsR2   = isAlu && (op != OpNot);
    assign writesDst = isAlu || isLoad;

    assign hazard = instr_valid && pendQ &&
                    ((readsR1 && (rdReg1 == pendRegQ)) ||
                     (readsR2 && (fS2 == pendRegQ)) ||
                     (writesDst && (fDst == pendRegQ)) ||
                     isLoad);

    assign instr_ready = (stateQ == StRun) && !hazard;
    assign accept      = instr_valid && instr_ready;
    assign ldWrite     = ld_done && pendQ;
    assign prevAlu     = (opcode >= 4'd2) && (opcode <= 4'd10);

    assign halted  = (stateQ == StHalted);
    assign illegal = illegalQ;

    // Reads see this cycle's writes; the ALU port overrides a colliding load return
    always_comb begin
        rdVal1 = regFile[rdReg1];
        if (ldWrite && (pendRegQ == rdReg1)) begin
            rdVal1 = ld_val;
        end
        if (wr_en && (wr_reg == rdReg1)) begin
            rdVal1 = wr_val;
        end
        rdVal2 = regFile[fS2];
        if (ldWrite && (pendRegQ == fS2)) begin
            rdVal2 = ld_val;
        end
        if (wr_en && (wr_reg == fS2)) begin
            rdVal2 = wr_val;
        end
    end

    always_comb begin
        opD   = OpNop;
        dstD  = 4'd0;
        s1D   = 16'd0;
        s2D   = 16'd0;
        addrD = 8'd0;
        u1D   = 1'b0;
        u2D   = 1'b0;
        if (accept) begin
            if (isAlu) begin
                opD  = op;
                dstD = fDst;
                s1D  = rdVal1;
                u1D  = prevAlu && (rdReg1 == destReg);
                if (readsR2) begin
                    s2D = rdVal2;
                    u2D = prevAlu && (fS2 == destReg);
                end
            end else if (isLoad) begin
                opD   = op;
                dstD  = fDst;
                addrD = instr[7:0];
            end else if (isStore) begin
                opD   = op;
                s1D   = rdVal1;
                addrD = instr[7:0];
                u1D   = prevAlu && (rdReg1 == destReg);
            end else if (isHlt) begin
                opD = OpHlt;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StRun: begin
                if (accept && isHlt) begin
                    stateD = StHalted;
                end else if (hazard && !ld_done) begin
                    stateD = StStall;
                end
            end
            StStall: begin
                if (ld_done || !pendQ) begin
                    stateD = StRun;
                end
            end
            StHalted: stateD = StHalted;
            default:  stateD = StRun;
        endcase
    end

    always_comb begin
        pendD    = pendQ;
        pendRegD = pendRegQ;
        if (accept && isLoad) begin
            pendD    = 1'b1;
            pendRegD = fDst;
        end else if (ld_done) begin
            pendD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= StRun;
            pendQ    <= 1'b0;
            pendRegQ <= 4'd0;
            illegalQ <= 1'b0;
            opcode   <= 4'd0;
            destReg  <= 4'd0;
            srcVal1  <= 16'd0;
            srcVal2  <= 16'd0;
            memAddr  <= 8'd0;
            used1    <= 1'b0;
            used2    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pendQ    <= pendD;
            pendRegQ <= pendRegD;
            if (accept && isIllegal) begin
                illegalQ <= 1'b1;
            end
            opcode   <= opD;
            destReg  <= dstD;
            srcVal1  <= s1D;
            srcVal2  <= s2D;
            memAddr  <= addrD;
            used1    <= u1D;
            used2    <= u2D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regFile[i] <= 16'd0;
            end
        end else begin
            if (ldWrite) begin
                regFile[pendRegQ] <= ld_val;
            end
            if (wr_en) begin
                regFile[wr_reg] <= wr_val;
            end
        end
    end

endmodule

// File: tb/tb_decode_operand_fetch.sv
// Bench for decode_operand_fetch: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the stage.
module tb_decode_operand_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_reg = 4'd0;
    logic [15:0] wr_val = 16'd0;
    logic        ld_done = 1'b0;
    logic [15:0] ld_val = 16'd0;
    logic [3:0]  opcode, destReg;
    logic [15:0] srcVal1, srcVal2;
    logic [7:0]  memAddr;
    logic        used1, used2, halted, illegal;

    int vectors = 0;
    int miscompares = 0;

    decode_operand_fetch dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .wr_en(wr_en), .wr_reg(wr_reg), .wr_val(wr_val),
        .ld_done(ld_done), .ld_val(ld_val), .opcode(opcode), .destReg(destReg),
        .srcVal1(srcVal1), .srcVal2(srcVal2), .memAddr(memAddr), .used1(used1),
        .used2(used2), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam int ModeRun = 0;
    localparam int ModeStall = 1;
    localparam int ModeHalted = 2;

    // Reference model: architectural registers, load scoreboard and expected issue
    logic [15:0] mRegs [16];
    logic        mPend;
    logic [3:0]  mPendReg;
    int          mMode;
    logic        mIllegal;
    logic [3:0]  eOp, eDst;
    logic [15:0] eS1, eS2;
    logic [7:0]  eAddr;
    logic        eU1, eU2, eReady, sReady;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mRegs[i] = 16'd0;
        mPend = 1'b0; mPendReg = 4'd0; mMode = ModeRun; mIllegal = 1'b0;
        eOp = 4'd0; eDst = 4'd0; eS1 = 16'd0; eS2 = 16'd0; eAddr = 8'd0;
        eU1 = 1'b0; eU2 = 1'b0; eReady = 1'b1;
    endtask

    task automatic model_step();
        logic [15:0] nr [16];
        logic [3:0] op, a, b, c, r1, prevDst;
        logic aluOp, rd1, rd2, wrd, conflict, acc, prevAlu;
        op = instr[15:12]; a = instr[11:8]; b = instr[7:4]; c = instr[3:0];
        aluOp = (op >= 4'd2) && (op <= 4'd10);
        r1 = (op == 4'd15) ? a : b;
        rd1 = aluOp || (op == 4'd15);
        rd2 = aluOp && (op != 4'd9);
        wrd = aluOp || (op == 4'd14);
        conflict = mPend && ((rd1 && r1 == mPendReg) || (rd2 && c == mPendReg) ||
                             (wrd && a == mPendReg) || (op == 4'd14));
        prevAlu = (eOp >= 4'd2) && (eOp <= 4'd10);
        prevDst = eDst;
        eReady = (mMode == ModeRun) && !(instr_valid && conflict);
        acc = instr_valid && eReady;
        // register contents after this edge; same-cycle reads observe them
        nr = mRegs;
        if (ld_done && mPend) nr[mPendReg] = ld_val;
        if (wr_en) nr[wr_reg] = wr_val;
        eOp = 4'd0; eDst = 4'd0; eS1 = 16'd0; eS2 = 16'd0; eAddr = 8'd0;
        eU1 = 1'b0; eU2 = 1'b0;
        if (acc) begin
            if (aluOp) begin
                eOp = op; eDst = a; eS1 = nr[b];
                eS2 = rd2 ? nr[c] : 16'd0;
                eU1 = prevAlu && (b == prevDst);
                eU2 = rd2 && prevAlu && (c == prevDst);
            end else if (op == 4'd14) begin
                eOp = op; eDst = a; eAddr = instr[7:0];
            end else if (op == 4'd15) begin
                eOp = op; eS1 = nr[a]; eAddr = instr[7:0];
                eU1 = prevAlu && (a == prevDst);
            end else if (op == 4'd1 || (op >= 4'd11 && op <= 4'd13)) begin
                eOp = 4'd1;
            end
        end
        if (mMode == ModeRun) begin
            if (acc && eOp == 4'd1) mMode = ModeHalted;
            else if (instr_valid && !eReady && !ld_done) mMode = ModeStall;
        end else if (mMode == ModeStall) begin
            if (ld_done || !mPend) mMode = ModeRun;
        end
        if (acc && op >= 4'd11 && op <= 4'd13) mIllegal = 1'b1;
        if (acc && op == 4'd14) begin
            mPend = 1'b1; mPendReg = a;
        end else if (ld_done) begin
            mPend = 1'b0;
        end
        mRegs = nr;
    endtask

    task automatic idle();
        instr_valid = 1'b0; wr_en = 1'b0; ld_done = 1'b0;
    endtask

    // Sample ready mid-cycle, advance the model, then step past the next rising edge
    task automatic tick();
        @(negedge clk);
        sReady = instr_ready;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        #1 rst = 1'b0;
        #2;
        vectors++;
        if ({opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2} !== 50'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2});
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        vectors++;
        if ({halted, illegal} !== 2'b00) begin
            miscompares++; $display("FAIL reset_flags: got %b want 00", {halted, illegal});
        end
    endtask

    task automatic test_rf_bypass();
        idle();
        wr_en = 1'b1; wr_reg = 4'd3; wr_val = 16'h1234;
        tick();
        wr_en = 1'b0; instr = 16'h2433; instr_valid = 1'b1;
        tick();
        vectors++;
        if ({opcode, srcVal1, srcVal2, used1, used2} !== {4'd2, 16'h1234, 16'h1234, 2'b00}) begin
            miscompares++;
            $display("FAIL add_r3: got op=%h s1=%h s2=%h u=%b%b want op=2 s1=1234 s2=1234 u=00",
                     opcode, srcVal1, srcVal2, used1, used2);
        end
        // write to R9 in the same cycle it is read
        wr_en = 1'b1; wr_reg = 4'd9; wr_val = 16'hBEEF; instr = 16'h2199;
        tick();
        vectors++;
        if ({srcVal1, srcVal2, destReg} !== {16'hBEEF, 16'hBEEF, 4'd1}) begin
            miscompares++;
            $display("FAIL bypass: got s1=%h s2=%h dst=%h want BEEF BEEF 1",
                     srcVal1, srcVal2, destReg);
        end
        idle();
    endtask

    task automatic test_forwarding();
        instr_valid = 1'b1; instr = 16'h2512;
        tick();
        instr = 16'h3655;
        tick();
        vectors++;
        if ({opcode, used1, used2} !== {4'd3, 2'b11}) begin
            miscompares++;
            $display("FAIL fwd_b2b: got op=%h u=%b%b want op=3 u=11", opcode, used1, used2);
        end
        instr = 16'h2512;
        tick();
        instr_valid = 1'b0;
        tick();
        vectors++;
        if (opcode !== 4'd0) begin
            miscompares++; $display("FAIL bubble_nop: got op=%h want 0", opcode);
        end
        instr_valid = 1'b1; instr = 16'h3655;
        tick();
        vectors++;
        if ({opcode, used1, used2} !== {4'd3, 2'b00}) begin
            miscompares++;
            $display("FAIL fwd_bubble: got op=%h u=%b%b want op=3 u=00", opcode, used1, used2);
        end
        idle();
    endtask

    task automatic test_load_stall();
        instr_valid = 1'b1; instr = 16'hE740;
        tick();
        vectors++;
        if ({opcode, destReg, memAddr, srcVal1, srcVal2} !== {4'd14, 4'd7, 8'h40, 32'd0}) begin
            miscompares++;
            $display("FAIL load_issue: got op=%h dst=%h addr=%h s1=%h s2=%h want E 7 40 0 0",
                     opcode, destReg, memAddr, srcVal1, srcVal2);
        end
        instr = 16'h2871;
        for (int i = 0; i < 4; i++) begin
            ld_done = (i == 3); ld_val = 16'h00FF;
            tick();
            vectors++;
            if ({sReady, opcode, used1, used2} !== 7'd0) begin
                miscompares++;
                $display("FAIL stall_%0d: got rdy=%b op=%h u=%b%b want 0 0 00",
                         i, sReady, opcode, used1, used2);
            end
        end
        ld_done = 1'b0;
        tick();
        vectors++;
        if ({sReady, opcode, destReg, srcVal1} !== {1'b1, 4'd2, 4'd8, 16'h00FF}) begin
            miscompares++;
            $display("FAIL after_load: got rdy=%b op=%h dst=%h s1=%h want 1 2 8 00FF",
                     sReady, opcode, destReg, srcVal1);
        end
        idle();
    endtask

    task automatic test_dual_write();
        instr_valid = 1'b1; instr = 16'hE710;
        tick();
        instr_valid = 1'b0;
        wr_en = 1'b1; wr_reg = 4'd7; wr_val = 16'hAAAA;
        ld_done = 1'b1; ld_val = 16'h5555;
        tick();
        idle();
        instr_valid = 1'b1; instr = 16'h2277;
        tick();
        vectors++;
        if ({srcVal1, srcVal2} !== {16'hAAAA, 16'hAAAA}) begin
            miscompares++;
            $display("FAIL dual_write: got s1=%h s2=%h want AAAA AAAA", srcVal1, srcVal2);
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        instr_valid = 1'b1; instr = 16'hE322;
        tick();
        instr = 16'h2433;
        tick();
        tick();
        vectors++;
        if (sReady !== 1'b0) begin
            miscompares++; $display("FAIL mid_stall_ready: got %b want 0", sReady);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2, halted} !== 51'd0) begin
            miscompares++;
            $display("FAIL mid_stall_reset: got op=%h dst=%h halted=%b want all 0",
                     opcode, destReg, halted);
        end
        model_reset();
        rst = 1'b1;
        tick();
        vectors++;
        if ({sReady, opcode, srcVal1} !== {1'b1, 4'd2, 16'h0000}) begin
            miscompares++;
            $display("FAIL post_reset_issue: got rdy=%b op=%h s1=%h want 1 2 0000",
                     sReady, opcode, srcVal1);
        end
        idle();
    endtask

    task automatic test_halt();
        instr_valid = 1'b1; instr = 16'hC000;
        tick();
        vectors++;
        if ({opcode, illegal, halted} !== {4'd1, 2'b11}) begin
            miscompares++;
            $display("FAIL halt_issue: got op=%h ill=%b hlt=%b want 1 1 1",
                     opcode, illegal, halted);
        end
        instr = 16'h2512;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({sReady, opcode, halted, illegal} !== {1'b0, 4'd0, 2'b11}) begin
                miscompares++;
                $display("FAIL halted_%0d: got rdy=%b op=%h hlt=%b ill=%b want 0 0 1 1",
                         i, sReady, opcode, halted, illegal);
            end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({halted, illegal} !== 2'b00) begin
            miscompares++; $display("FAIL halt_reset: got %b want 00", {halted, illegal});
        end
        model_reset();
        rst = 1'b1;
        idle();
    endtask

    task automatic test_random();
        logic [3:0] op;
        int unsigned k;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (mMode == ModeHalted && $urandom_range(0, 3) == 0) do_reset();
            k = $urandom_range(0, 99);
            if (k < 2) op = 4'd1;
            else if (k < 4) op = 4'($urandom_range(11, 13));
            else if (k < 12) op = 4'd0;
            else if (k < 30) op = 4'd14;
            else if (k < 42) op = 4'd15;
            else op = 4'($urandom_range(2, 10));
            instr = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3))};
            if (op >= 4'd14) instr[7:0] = 8'($urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            wr_en = ($urandom_range(0, 2) == 0);
            wr_reg = 4'($urandom_range(0, 5));
            wr_val = 16'($urandom);
            ld_done = mPend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            ld_val = 16'($urandom);
            tick();
            vectors++;
            if (sReady !== eReady) begin
                miscompares++; $display("FAIL rnd_ready @%0d: got %b want %b", n, sReady, eReady);
            end
            vectors++;
            if ({opcode, destReg, memAddr} !== {eOp, eDst, eAddr}) begin
                miscompares++;
                $display("FAIL rnd_decode @%0d: got op=%h dst=%h addr=%h want %h %h %h",
                         n, opcode, destReg, memAddr, eOp, eDst, eAddr);
            end
            vectors++;
            if ({srcVal1, srcVal2} !== {eS1, eS2}) begin
                miscompares++;
                $display("FAIL rnd_operands @%0d: got %h %h want %h %h",
                         n, srcVal1, srcVal2, eS1, eS2);
            end
            vectors++;
            if ({used1, used2} !== {eU1, eU2}) begin
                miscompares++;
                $display("FAIL rnd_used @%0d: got %b%b want %b%b", n, used1, used2, eU1, eU2);
            end
            vectors++;
            if ({halted, illegal} !== {(mMode == ModeHalted), mIllegal}) begin
                miscompares++;
                $display("FAIL rnd_flags @%0d: got %b%b want %b%b",
                         n, halted, illegal, (mMode == ModeHalted), mIllegal);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rf_bypass();
        test_forwarding();
        test_load_stall();
        test_dual_write();
        test_reset_mid_stall();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_operand_fetch.md
DECODE_OPERAND_FETCH -- requirements
Module: decode_operand_fetch

Interface
REQ-001 SHALL have parameter: HALT_ON_ILLEGAL, default 1, when 1 opcodes 11-13 issue as HLT, when 0 they issue as NOP.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: instr  input  16  instruction from fetch; instr_valid  input  1; instr_ready  output  1  (accepted when valid && ready at posedge).
REQ-005 SHALL have ports: wr_en  input  1, wr_reg  input  4, wr_val  input  16  ALU writeback port.
REQ-006 SHALL have ports: ld_done  input  1, ld_val  input  16  load-return writeback to the pending load register.
REQ-007 SHALL have registered outputs to execute: opcode 4, destReg 4, srcVal1 16, srcVal2 16, memAddr 8, used1 1, used2 1.
REQ-008 SHALL have outputs: halted  1  HALTED state; illegal  1  sticky illegal-opcode flag.

Function
REQ-009 SHALL decode instr as opcode=[15:12], dst=[11:8], s1=[7:4], s2=[3:0]; LOAD(14): destReg=[11:8], memAddr=[7:0]; STORE(15): source s1=[11:8], memAddr=[7:0].
REQ-010 SHALL hold a 16x16 register file; writes at posedge; wr_en and ld_done to the same register in one cycle: wr_val wins.
REQ-011 SHALL bypass same-cycle writes: a read of a register being written this cycle returns the written value.
REQ-012 SHALL issue one instruction per cycle, one-cycle latency: instruction accepted at edge N appears on outputs after edge N.
REQ-013 SHALL set used1 when issued instruction reads s1 (opcodes 2-10, 15) and s1 equals destReg of the immediately preceding issued instruction with opcode 2-10; used2 likewise for s2 (opcodes 2-8, 10).
REQ-014 SHALL never set used1/used2 across a bubble (NOP issued in between clears forwarding match).
REQ-015 SHALL keep a one-entry scoreboard: set on LOAD issue (pend_reg=destReg), cleared on ld_done.
REQ-016 SHALL stall while the instruction at instr reads or writes pend_reg while pending, or is a LOAD while pending: instr_ready=0, issue NOP (opcode 0, used1=used2=0).
REQ-017 SHALL issue NOP whenever instr_valid=0 in RUN.
REQ-018 SHALL implement states RUN, STALL, HALTED: RUN->STALL on hazard; STALL->RUN in the cycle after ld_done; RUN->HALTED on issuing HLT (opcode 1 or illegal with HALT_ON_ILLEGAL=1).
REQ-019 SHALL in HALTED hold instr_ready=0, halted=1, issue NOP; only reset exits.
REQ-020 SHALL set illegal=1 on accepting opcode 11-13, sticky until reset.
REQ-021 SHALL output zero for unused fields (srcVal2 for NOT/LOAD/STORE, memAddr for ALU ops).

Reset
REQ-022 SHALL on rst low immediately clear all outputs to 0, scoreboard, illegal and halted, enter RUN; instr_ready=1 after release.
REQ-023 SHALL clear all 16 registers to 0 on reset; reset mid-stall discards the pending load.

Verification
REQ-024 Reset, write R3=0x1234 via wr_en, issue ADD R4,R3,R3 -> srcVal1=srcVal2=0x1234, used1=used2=0, opcode=2 next cycle.
REQ-025 Issue ADD R5,R1,R2 then SUB R6,R5,R5 back-to-back -> second issue used1=used2=1; insert one NOP between -> used1=used2=0.
REQ-026 LOAD R7,0x40 then ADD R8,R7,R1 -> instr_ready=0, NOPs issued until ld_done with ld_val=0x00FF; ADD then issues with srcVal1=0x00FF.
REQ-027 wr_en and ld_done both to R7 same cycle (0xAAAA vs 0x5555) -> R7=0xAAAA.
REQ-028 Issue opcode 12 with HALT_ON_ILLEGAL=1 -> opcode=1 issued, illegal=1, halted=1, instr_ready=0 until rst low.
REQ-029 Assert rst low during STALL -> outputs 0, state RUN, scoreboard empty, instr_ready=1 after release.
